// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI types, idle levels and mode helpers
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;

  localparam logic MOSI_IDLE = 1'b0;

  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return cpol == cpha;
  endfunction

  function automatic logic sck_idle_level(input logic cpol);
    return cpol;
  endfunction

  function automatic logic cs_idle_level(input logic cs_polar);
    return ~cs_polar;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - two-flop synchroniser with configurable reset level
module spi_sync #(
  parameter logic P_RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= P_RST_VAL;
      sync_q <= P_RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/receiver.sv
// rtl/receiver.sv - SPI peripheral-side word receiver with one-word output buffer
module receiver
  import spi_pkg::*;
#(
  parameter int P_DATA_WIDTH = 8,
  parameter bit P_CS_POLAR   = 1'b0,
  parameter bit P_CPOL       = 1'b0,
  parameter bit P_CPHA       = 1'b0,
  parameter bit P_MSB_FIRST  = 1'b1
) (
  input  logic                    clk_100,
  input  logic                    s_rst,
  input  logic                    SCK,
  input  logic                    MOSI,
  input  logic                    CS,
  output logic [P_DATA_WIDTH-1:0] data,
  output logic                    valid,
  input  logic                    ready,
  output logic                    busy,
  output logic                    overrun,
  output logic                    frame_err
);

  localparam int              CW       = $clog2(P_DATA_WIDTH);
  localparam logic [CW-1:0]   LAST     = CW'(P_DATA_WIDTH - 1);
  localparam logic            SCK_IDLE = sck_idle_level(P_CPOL);
  localparam logic            CS_IDLE  = cs_idle_level(P_CS_POLAR);
  localparam logic            ON_RISE  = sample_on_rise(P_CPOL, P_CPHA);

  logic sck_s, mosi_s, cs_s;
  logic sck_dly_q, mosi_dly_q, cs_dly_q;
  logic sample_q;

  spi_sync #(.P_RST_VAL(SCK_IDLE)) u_sync_sck (
    .clk_i(clk_100), .rst_i(s_rst), .d_i(SCK), .q_o(sck_s)
  );
  spi_sync #(.P_RST_VAL(MOSI_IDLE)) u_sync_mosi (
    .clk_i(clk_100), .rst_i(s_rst), .d_i(MOSI), .q_o(mosi_s)
  );
  spi_sync #(.P_RST_VAL(CS_IDLE)) u_sync_cs (
    .clk_i(clk_100), .rst_i(s_rst), .d_i(CS), .q_o(cs_s)
  );

  // mosi_dly_q is aligned with the SCK sample that sets sample_q
  always_ff @(posedge clk_100) begin
    if (s_rst) begin
      sck_dly_q  <= SCK_IDLE;
      mosi_dly_q <= MOSI_IDLE;
      cs_dly_q   <= CS_IDLE;
      sample_q   <= 1'b0;
    end else begin
      sck_dly_q  <= sck_s;
      mosi_dly_q <= mosi_s;
      cs_dly_q   <= cs_s;
      sample_q   <= ON_RISE ? (sck_s & ~sck_dly_q) : (~sck_s & sck_dly_q);
    end
  end

  logic cs_active;
  assign cs_active = (cs_dly_q == P_CS_POLAR);

  rx_state_t               state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [P_DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [P_DATA_WIDTH-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;
  logic                    frame_err_q, frame_err_d;
  logic [P_DATA_WIDTH-1:0] shifted;
  logic                    word_done;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;
    word_done   = 1'b0;
    shifted     = P_MSB_FIRST ? {shreg_q[P_DATA_WIDTH-2:0], mosi_dly_q}
                              : {mosi_dly_q, shreg_q[P_DATA_WIDTH-1:1]};

    case (state_q)
      IDLE: begin
        if (cs_active) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shreg_d = '0;
        end
      end
      SHIFT: begin
        if (!cs_active) begin
          state_d     = IDLE;
          frame_err_d = (cnt_q != '0);
          cnt_d       = '0;
          shreg_d     = '0;
        end else if (sample_q) begin
          shreg_d = shifted;
          if (cnt_q == LAST) begin
            cnt_d     = '0;
            word_done = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A completing word may replace the buffered one only if it leaves this cycle
    if (word_done) begin
      if (!valid_q || ready) begin
        data_d  = shifted;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_100) begin
    if (s_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign busy      = (state_q == SHIFT);
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule
